reg_dump: RTL and testbench

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump.sv | 83 ++++++++
 tb/tb_reg_dump.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump.sv
// Register-file dump engine: walks indices START_REG..LAST_REG, reads each
// register through a combinational read port and streams it out on a valid/ready handshake.
module reg_dump #(
    parameter int unsigned LAST_REG  = 31,
    parameter int unsigned START_REG = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    output logic [4:0]  A,
    input  logic [31:0] RD,
    output logic [31:0] DOUT,
    output logic [4:0]  DIDX,
    output logic        DVALID,
    input  logic        DREADY,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        FIN
    } state_t;

    localparam logic [4:0] LastIdx  = 5'(LAST_REG);
    localparam logic [4:0] StartIdx = 5'(START_REG);

    state_t     state_q;
    logic [4:0] idx_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            idx_q   <= 5'd0;
            DOUT    <= 32'd0;
            DIDX    <= 5'd0;
            DVALID  <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        idx_q   <= StartIdx;
                        state_q <= READ;
                    end
                end
                READ: begin
                    // Snapshot the read data; later register-file writes cannot disturb it.
                    DOUT    <= RD;
                    DIDX    <= idx_q;
                    DVALID  <= 1'b1;
                    state_q <= SEND;
                end
                SEND: begin
                    if (DVALID && DREADY) begin
                        DVALID <= 1'b0;
                        if (idx_q == LastIdx) begin
                            DONE    <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            idx_q   <= idx_q + 5'd1;
                            state_q <= READ;
                        end
                    end
                end
                FIN: begin
                    DONE    <= 1'b0;
                    idx_q   <= 5'd0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign A    = idx_q;
    assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: full dump, stall, capture isolation, START
// re-pulse, mid-dump reset and a single-word configuration.
module tb_reg_dump;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        DREADY = 1'b1;
    logic [4:0]  A, DIDX;
    logic [31:0] RD, DOUT;
    logic        DVALID, BUSY, DONE;

    logic        s_start = 1'b0;
    logic [4:0]  s_a, s_didx;
    logic [31:0] s_rd, s_dout;
    logic        s_dvalid, s_busy, s_done;

    logic [31:0] rf [32];
    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    assign RD   = rf[A];
    assign s_rd = rf[s_a];

    reg_dump dut (
        .CLK(CLK), .RST(RST), .START(START), .A(A), .RD(RD), .DOUT(DOUT), .DIDX(DIDX),
        .DVALID(DVALID), .DREADY(DREADY), .BUSY(BUSY), .DONE(DONE)
    );

    reg_dump #(.LAST_REG(5), .START_REG(5)) dut5 (
        .CLK(CLK), .RST(RST), .START(s_start), .A(s_a), .RD(s_rd), .DOUT(s_dout),
        .DIDX(s_didx), .DVALID(s_dvalid), .DREADY(DREADY), .BUSY(s_busy), .DONE(s_done)
    );

    function automatic logic [31:0] xval(int i);
        return 32'(i) * 32'h11111111;
    endfunction

    task automatic start_dump();
        @(posedge CLK); #1 START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
    endtask

    task automatic wait_word(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge CLK); #1;
            if (DVALID === 1'b1 && DIDX === 5'(n)) ok = 1'b1;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) ok = 1'b1;
        end
        if (ok) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (A !== 5'd0 || DOUT !== 32'd0 || DIDX !== 5'd0 || DVALID !== 1'b0 ||
            BUSY !== 1'b0 || DONE !== 1'b0) begin
            bad++;
            $display("FAIL reset: A=%0d DOUT=%h DIDX=%0d DVALID=%b BUSY=%b DONE=%b want all 0",
                     A, DOUT, DIDX, DVALID, BUSY, DONE);
        end
        total++;
        if (s_a !== 5'd0 || s_busy !== 1'b0 || s_dvalid !== 1'b0 || s_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_single: A=%0d BUSY=%b DVALID=%b DONE=%b want all 0",
                     s_a, s_busy, s_dvalid, s_done);
        end
        @(posedge CLK); #1 RST = 1'b0;
    endtask

    task automatic test_full_dump();
        int dones;
        dones = 0;
        start_dump();
        total++;
        if (A !== 5'd0 || BUSY !== 1'b1 || DVALID !== 1'b0) begin
            bad++;
            $display("FAIL full_first: A=%0d BUSY=%b DVALID=%b want A=0 BUSY=1 DVALID=0",
                     A, BUSY, DVALID);
        end
        for (int c = 1; c <= 65; c++) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) dones++;
            total++;
            if (c % 2 == 1 && c < 64) begin
                if (DVALID !== 1'b1 || DIDX !== 5'(c / 2) || DOUT !== xval(c / 2)) begin
                    bad++;
                    $display("FAIL full_word c=%0d: DVALID=%b DIDX=%0d DOUT=%h want 1 %0d %h",
                             c, DVALID, DIDX, DOUT, c / 2, xval(c / 2));
                end
            end else if (c <= 64) begin
                if (DVALID !== 1'b0 || DONE !== 1'(c == 64) ||
                    A !== ((c < 64) ? 5'(c / 2) : 5'd31)) begin
                    bad++;
                    $display("FAIL full_gap c=%0d: DVALID=%b DONE=%b A=%0d want 0 %0d %0d",
                             c, DVALID, DONE, A, c == 64, (c < 64) ? c / 2 : 31);
                end
            end else begin
                if (BUSY !== 1'b0 || DONE !== 1'b0 || A !== 5'd0) begin
                    bad++;
                    $display("FAIL full_end: BUSY=%b DONE=%b A=%0d want 0 0 0", BUSY, DONE, A);
                end
            end
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL full_done_count: got %0d want 1", dones);
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit seen;
        int next;
        start_dump();
        wait_word(7, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL stall_reach: word 7 not seen, want seen");
        end
        DREADY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK); #1;
            total++;
            if (DVALID !== 1'b1 || DIDX !== 5'd7 || DOUT !== xval(7)) begin
                bad++;
                $display("FAIL stall_hold k=%0d: DVALID=%b DIDX=%0d DOUT=%h want 1 7 %h",
                         k, DVALID, DIDX, DOUT, xval(7));
            end
        end
        DREADY = 1'b1;
        next = 8;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge CLK); #1;
            if (DVALID === 1'b1) begin
                total++;
                if (next > 31 || DIDX !== 5'(next) || DOUT !== xval(next)) begin
                    bad++;
                    $display("FAIL stall_seq: DIDX=%0d DOUT=%h want index %0d", DIDX, DOUT, next);
                end
                next++;
            end
            if (DONE === 1'b1) seen = 1'b1;
        end
        total++;
        if (next != 32 || !seen) begin
            bad++;
            $display("FAIL stall_end: next=%0d done=%b want 32 1", next, seen);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_write_during_send();
        bit ok;
        start_dump();
        wait_word(3, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wr_reach: word 3 not seen, want seen");
        end
        DREADY = 1'b0;
        rf[3] = 32'hDEADBEEF;
        @(posedge CLK); #1;
        total++;
        if (DOUT !== xval(3) || DIDX !== 5'd3 || DVALID !== 1'b1) begin
            bad++;
            $display("FAIL wr_hold: DOUT=%h DIDX=%0d DVALID=%b want %h 3 1",
                     DOUT, DIDX, DVALID, xval(3));
        end
        DREADY = 1'b1;
        wait_done(ok);
        start_dump();
        wait_word(3, ok);
        total++;
        if (!ok || DOUT !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL wr_second: DOUT=%h seen=%b want deadbeef 1", DOUT, ok);
        end
        wait_done(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wr_done: DONE not seen, want seen");
        end
        rf[3] = xval(3);
    endtask

    task automatic test_start_ignored();
        bit ok;
        int next;
        int dones;
        start_dump();
        wait_word(10, ok);
        START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
        total++;
        if (!ok || BUSY !== 1'b1 || A !== 5'd11 || DVALID !== 1'b0) begin
            bad++;
            $display("FAIL restart_mid: seen=%b BUSY=%b A=%0d DVALID=%b want 1 1 11 0",
                     ok, BUSY, A, DVALID);
        end
        next = 11;
        dones = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) dones++;
            if (DVALID === 1'b1) begin
                total++;
                if (next > 31 || DIDX !== 5'(next) || DOUT !== xval(next)) begin
                    bad++;
                    $display("FAIL restart_seq: DIDX=%0d DOUT=%h want index %0d", DIDX, DOUT, next);
                end
                next++;
            end
        end
        total++;
        if (dones != 1 || next != 32 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL restart_end: dones=%0d next=%0d BUSY=%b want 1 32 0", dones, next, BUSY);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        start_dump();
        wait_word(15, ok);
        #2 RST = 1'b1;
        #1;
        total++;
        if (!ok || DVALID !== 1'b0 || BUSY !== 1'b0 || A !== 5'd0 || DOUT !== 32'd0 ||
            DIDX !== 5'd0 || DONE !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: seen=%b DVALID=%b BUSY=%b A=%0d DOUT=%h DIDX=%0d want 1 0 0 0 0 0",
                     ok, DVALID, BUSY, A, DOUT, DIDX);
        end
        @(posedge CLK); #1 RST = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK); #1;
            total++;
            if (DVALID !== 1'b0 || BUSY !== 1'b0) begin
                bad++;
                $display("FAIL rst_quiet k=%0d: DVALID=%b BUSY=%b want 0 0", k, DVALID, BUSY);
            end
        end
        start_dump();
        total++;
        if (A !== 5'd0 || BUSY !== 1'b1) begin
            bad++;
            $display("FAIL rst_restart: A=%0d BUSY=%b want 0 1", A, BUSY);
        end
        @(posedge CLK); #1;
        total++;
        if (DVALID !== 1'b1 || DIDX !== 5'd0 || DOUT !== xval(0)) begin
            bad++;
            $display("FAIL rst_word0: DVALID=%b DIDX=%0d DOUT=%h want 1 0 0", DVALID, DIDX, DOUT);
        end
        wait_word(1, ok);
        total++;
        if (!ok || DOUT !== xval(1)) begin
            bad++;
            $display("FAIL rst_word1: DOUT=%h seen=%b want %h 1", DOUT, ok, xval(1));
        end
        wait_done(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rst_done: DONE not seen, want seen");
        end
    endtask

    task automatic test_single();
        @(posedge CLK); #1 s_start = 1'b1;
        @(posedge CLK); #1 s_start = 1'b0;
        total++;
        if (s_a !== 5'd5 || s_busy !== 1'b1 || s_dvalid !== 1'b0) begin
            bad++;
            $display("FAIL single_read: A=%0d BUSY=%b DVALID=%b want 5 1 0", s_a, s_busy, s_dvalid);
        end
        @(posedge CLK); #1;
        total++;
        if (s_dvalid !== 1'b1 || s_didx !== 5'd5 || s_dout !== xval(5) || s_done !== 1'b0) begin
            bad++;
            $display("FAIL single_word: DVALID=%b DIDX=%0d DOUT=%h DONE=%b want 1 5 %h 0",
                     s_dvalid, s_didx, s_dout, s_done, xval(5));
        end
        @(posedge CLK); #1;
        total++;
        if (s_dvalid !== 1'b0 || s_done !== 1'b1 || s_busy !== 1'b1) begin
            bad++;
            $display("FAIL single_done: DVALID=%b DONE=%b BUSY=%b want 0 1 1",
                     s_dvalid, s_done, s_busy);
        end
        @(posedge CLK); #1;
        total++;
        if (s_done !== 1'b0 || s_busy !== 1'b0 || s_a !== 5'd0 || s_dvalid !== 1'b0) begin
            bad++;
            $display("FAIL single_idle: DONE=%b BUSY=%b A=%0d DVALID=%b want 0 0 0 0",
                     s_done, s_busy, s_a, s_dvalid);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = xval(i);
        test_reset();
        test_full_dump();
        test_stall();
        test_write_during_send();
        test_start_ignored();
        test_reset_mid();
        test_single();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "watchdog");
    end

endmodule
